lifo_stack_mc: RTL and testbench

//   Multi-channel, pointer-based LIFO stack. Holds NUM_CH independent stacks of STACK_SIZE entries each.

---
 rtl/lifo_pkg.sv | 23 ++
 rtl/lifo_sp_ctrl.sv | 75 +++++++
 rtl/lifo_stack_mc.sv | 127 ++++++++++++
 tb/tb_lifo_stack_mc.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// Shared types and sizing helpers for the multi-channel LIFO stack.
package lifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } lifo_op_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic lifo_op_t decode_op(input logic push, input logic pop);
        return lifo_op_t'({push, pop});
    endfunction

endpackage

// File: rtl/lifo_sp_ctrl.sv
// Per-channel stack pointer: tracks fill level and turns the decoded op into
// storage strobes and error indications for the selected channel.
module lifo_sp_ctrl
    import lifo_pkg::*;
#(
    parameter int STACK_SIZE = 4,
    parameter int CNT_W      = 3
) (
    input  logic             w_clk,
    input  logic             reset,
    input  logic             en,
    input  lifo_op_t         op,
    output logic [CNT_W-1:0] sp,
    output logic             full,
    output logic             empty,
    output logic             do_write,
    output logic             do_read,
    output logic             do_bypass,
    output logic             ovf,
    output logic             unf
);

    logic [CNT_W-1:0] sp_nxt;

    assign full  = (sp == CNT_W'(STACK_SIZE));
    assign empty = (sp == '0);

    always_comb begin
        sp_nxt    = sp;
        do_write  = 1'b0;
        do_read   = 1'b0;
        do_bypass = 1'b0;
        ovf       = 1'b0;
        unf       = 1'b0;
        if (en) begin
            case (op)
                OP_PUSH: begin
                    if (full) begin
                        ovf = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        sp_nxt   = sp + 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf = 1'b1;
                    end else begin
                        do_read = 1'b1;
                        sp_nxt  = sp - 1'b1;
                    end
                end
                // Swap replaces the top in place; on an empty stack the word passes straight through.
                OP_SWAP: begin
                    if (empty) begin
                        do_bypass = 1'b1;
                    end else begin
                        do_read  = 1'b1;
                        do_write = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (reset) begin
            sp <= '0;
        end else begin
            sp <= sp_nxt;
        end
    end

endmodule

// File: rtl/lifo_stack_mc.sv
// Multi-channel pointer-based LIFO with swap, per-channel flags and error pulses.
// Optional LIFO_PEEK_EN adds a combinational peek_data output of the selected top.
module lifo_stack_mc
    import lifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STACK_SIZE = 4,
    parameter int NUM_CH     = 2,
    localparam int CH_W      = clog2_min1(NUM_CH),
    localparam int CNT_W     = cnt_w(STACK_SIZE)
) (
    input  logic                  w_clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic [NUM_CH-1:0]     full,
    output logic [NUM_CH-1:0]     empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
`ifdef LIFO_PEEK_EN
    ,
    output logic [DATA_WIDTH-1:0] peek_data
`endif
);

    localparam int ADDR_W = clog2_min1(STACK_SIZE);

    lifo_op_t              op;
    logic [DATA_WIDTH-1:0] mem      [NUM_CH][STACK_SIZE];
    logic [CNT_W-1:0]      sp       [NUM_CH];
    logic [ADDR_W-1:0]     top_addr [NUM_CH];
    logic [ADDR_W-1:0]     wr_addr  [NUM_CH];
    logic [NUM_CH-1:0]     do_write;
    logic [NUM_CH-1:0]     do_read;
    logic [NUM_CH-1:0]     do_bypass;
    logic [NUM_CH-1:0]     ovf;
    logic [NUM_CH-1:0]     unf;
    logic [DATA_WIDTH-1:0] rd_word;

    assign op = decode_op(push, pop);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lifo_sp_ctrl #(
            .STACK_SIZE (STACK_SIZE),
            .CNT_W      (CNT_W)
        ) u_sp_ctrl (
            .w_clk     (w_clk),
            .reset     (reset),
            .en        (ch_sel == CH_W'(c)),
            .op        (op),
            .sp        (sp[c]),
            .full      (full[c]),
            .empty     (empty[c]),
            .do_write  (do_write[c]),
            .do_read   (do_read[c]),
            .do_bypass (do_bypass[c]),
            .ovf       (ovf[c]),
            .unf       (unf[c])
        );

        assign top_addr[c] = ADDR_W'(sp[c] - 1'b1);
        assign wr_addr[c]  = (op == OP_SWAP) ? top_addr[c] : ADDR_W'(sp[c]);
    end

    // Storage is deliberately left out of reset; validity lives in the pointers.
    always_ff @(posedge w_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (do_write[c]) begin
                mem[c][wr_addr[c]] <= write_data;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (do_read[c]) begin
                rd_word = mem[c][top_addr[c]];
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            read_valid <= |do_read | |do_bypass;
            overflow   <= |ovf;
            underflow  <= |unf;
            if (|do_read) begin
                read_data <= rd_word;
            end else if (|do_bypass) begin
                read_data <= write_data;
            end
        end
    end

    // An out-of-range ch_sel matches no channel, so count falls back to zero.
    always_comb begin
        count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c)) begin
                count = sp[c];
            end
        end
    end

`ifdef LIFO_PEEK_EN
    always_comb begin
        peek_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c) && !empty[c]) begin
                peek_data = mem[c][top_addr[c]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lifo_stack_mc.sv
// Bench for lifo_stack_mc: directed scenarios plus random traffic checked against a queue model.
module tb_lifo_stack_mc;

    localparam int DW    = 8;
    localparam int SS    = 4;
    localparam int NC    = 3;
    localparam int CH_W  = 2;
    localparam int CNT_W = 3;

    logic            w_clk = 1'b0;
    logic            reset = 1'b0;
    logic            push  = 1'b0;
    logic            pop   = 1'b0;
    logic [CH_W-1:0] ch_sel = '0;
    logic [DW-1:0]   write_data = '0;
    logic [DW-1:0]   read_data;
    logic            read_valid;
    logic [NC-1:0]   full;
    logic [NC-1:0]   empty;
    logic [CNT_W-1:0] count;
    logic            overflow;
    logic            underflow;
`ifdef LIFO_PEEK_EN
    logic [DW-1:0]   peek_data;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [DW-1:0] stk [NC][$];
    logic [DW-1:0] e_rd  = '0;
    logic          e_rv  = 1'b0;
    logic          e_ovf = 1'b0;
    logic          e_unf = 1'b0;

    lifo_stack_mc #(
        .DATA_WIDTH (DW),
        .STACK_SIZE (SS),
        .NUM_CH     (NC)
    ) dut (
        .w_clk      (w_clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .ch_sel     (ch_sel),
        .write_data (write_data),
        .read_data  (read_data),
        .read_valid (read_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef LIFO_PEEK_EN
        ,
        .peek_data  (peek_data)
`endif
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one queue per channel, updated from the inputs seen at each edge.
    always @(posedge w_clk) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) stk[c].delete();
            e_rd = '0; e_rv = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
        end else begin
            e_rv = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
            if (int'(ch_sel) < NC) begin
                int ch;
                int n;
                ch = int'(ch_sel);
                n  = stk[ch].size();
                if (push && pop) begin
                    e_rv = 1'b1;
                    if (n == 0) begin
                        e_rd = write_data;
                    end else begin
                        e_rd = stk[ch][n-1];
                        stk[ch][n-1] = write_data;
                    end
                end else if (push) begin
                    if (n == SS) e_ovf = 1'b1;
                    else stk[ch].push_back(write_data);
                end else if (pop) begin
                    if (n == 0) begin
                        e_unf = 1'b1;
                    end else begin
                        e_rd = stk[ch].pop_back();
                        e_rv = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge w_clk) begin
        if (chk_en) begin
            logic [NC-1:0] e_full;
            logic [NC-1:0] e_empty;
            int            e_cnt;
            for (int c = 0; c < NC; c++) begin
                e_full[c]  = (stk[c].size() == SS);
                e_empty[c] = (stk[c].size() == 0);
            end
            e_cnt = (int'(ch_sel) < NC) ? stk[int'(ch_sel)].size() : 0;
            chk("read_data",  32'(read_data),  32'(e_rd));
            chk("read_valid", 32'(read_valid), 32'(e_rv));
            chk("overflow",   32'(overflow),   32'(e_ovf));
            chk("underflow",  32'(underflow),  32'(e_unf));
            chk("full",       32'(full),       32'(e_full));
            chk("empty",      32'(empty),      32'(e_empty));
            chk("count",      32'(count),      32'(e_cnt));
`ifdef LIFO_PEEK_EN
            if (int'(ch_sel) < NC && stk[int'(ch_sel)].size() > 0)
                chk("peek_data", 32'(peek_data), 32'(stk[int'(ch_sel)][$]));
            else
                chk("peek_data", 32'(peek_data), 32'd0);
`endif
        end
    end

    // Drive one cycle of inputs; on return the registered outputs reflect that cycle.
    task automatic cyc(input logic ps, input logic pp, input int ch, input logic [DW-1:0] d);
        push = ps; pop = pp; ch_sel = CH_W'(ch); write_data = d;
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        // Reset and initial state
        reset = 1'b1;
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("rst_empty", 32'(empty), 32'h7);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_rdata", 32'(read_data), 32'h0);
        chk("rst_rvalid", 32'(read_valid), 32'h0);

        // Push then pop in reverse order, zero data included
        cyc(1, 0, 0, 8'h00);
        cyc(1, 0, 0, 8'h11);
        cyc(1, 0, 0, 8'h22);
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_empty0", 32'(empty[0]), 32'd0);
        cyc(0, 1, 0, 8'h00);
        chk("t1_pop22", 32'(read_data), 32'h22);
        chk("t1_rv", 32'(read_valid), 32'd1);
        cyc(0, 1, 0, 8'h00);
        chk("t1_pop11", 32'(read_data), 32'h11);
        cyc(0, 1, 0, 8'h00);
        chk("t1_pop00", 32'(read_data), 32'h00);
        chk("t1_rv0", 32'(read_valid), 32'd1);
        chk("t1_empty_end", 32'(empty[0]), 32'd1);

        // Overflow on ch1
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, DW'(8'hA0 + i));
            if (i == 3) chk("t2_full", 32'(full[1]), 32'd1);
        end
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_count", 32'(count), 32'd4);
        cyc(0, 0, 1, 8'h00);
        chk("t2_ovf_clr", 32'(overflow), 32'd0);
        cyc(0, 1, 1, 8'h00);
        chk("t2_top", 32'(read_data), 32'hA3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'h00);
        chk("t2_last", 32'(read_data), 32'hA0);

        // Underflow holds read_data
        cyc(0, 1, 0, 8'h00);
        chk("t3_unf", 32'(underflow), 32'd1);
        chk("t3_rv", 32'(read_valid), 32'd0);
        chk("t3_hold", 32'(read_data), 32'hA0);
        cyc(0, 0, 0, 8'h00);
        chk("t3_unf_clr", 32'(underflow), 32'd0);

        // Swap and bypass
        cyc(1, 0, 0, 8'hA1);
        cyc(1, 0, 0, 8'hB2);
        cyc(1, 1, 0, 8'h5C);
        chk("t4_swap_rd", 32'(read_data), 32'hB2);
        chk("t4_swap_rv", 32'(read_valid), 32'd1);
        chk("t4_swap_cnt", 32'(count), 32'd2);
        cyc(0, 1, 0, 8'h00);
        chk("t4_pop5c", 32'(read_data), 32'h5C);
        cyc(0, 1, 0, 8'h00);
        chk("t4_popa1", 32'(read_data), 32'hA1);
        cyc(1, 1, 1, 8'h7E);
        chk("t4_byp_rd", 32'(read_data), 32'h7E);
        chk("t4_byp_empty", 32'(empty[1]), 32'd1);
        chk("t4_byp_unf", 32'(underflow), 32'd0);

        // Swap on a full channel does not overflow
        for (int i = 0; i < 4; i++) cyc(1, 0, 2, DW'(8'hC0 + i));
        cyc(1, 1, 2, 8'hEE);
        chk("swapfull_rd", 32'(read_data), 32'hC3);
        chk("swapfull_ovf", 32'(overflow), 32'd0);
        cyc(0, 1, 2, 8'h00);
        chk("swapfull_top", 32'(read_data), 32'hEE);

        // Invalid channel is ignored
        cyc(1, 0, 3, 8'h55);
        chk("inv_count", 32'(count), 32'd0);
        chk("inv_ovf", 32'(overflow), 32'd0);
        cyc(0, 1, 3, 8'h00);
        chk("inv_unf", 32'(underflow), 32'd0);

        // Interleaved channels
        cyc(1, 0, 0, 8'h10);
        cyc(1, 0, 1, 8'h30);
        cyc(1, 0, 0, 8'h20);
        cyc(1, 0, 1, 8'h40);
        cyc(0, 1, 0, 8'h00); chk("t5_c0a", 32'(read_data), 32'h20);
        cyc(0, 1, 0, 8'h00); chk("t5_c0b", 32'(read_data), 32'h10);
        cyc(0, 1, 1, 8'h00); chk("t5_c1a", 32'(read_data), 32'h40);
        cyc(0, 1, 1, 8'h00); chk("t5_c1b", 32'(read_data), 32'h30);

        // Reset wins over a simultaneous push
        cyc(1, 0, 0, 8'h99);
        reset = 1'b1;
        cyc(1, 0, 0, 8'h77);
        reset = 1'b0;
        cyc(0, 0, 0, 8'h00);
        chk("t5_rst_empty", 32'(empty), 32'h7);
        chk("t5_rst_count", 32'(count), 32'd0);

`ifdef LIFO_PEEK_EN
        cyc(1, 0, 0, 8'h3C);
        chk("t6_peek", 32'(peek_data), 32'h3C);
        chk("t6_count", 32'(count), 32'd1);
        cyc(0, 0, 1, 8'h00);
        chk("t6_peek_empty", 32'(peek_data), 32'h0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic ps;
            logic pp;
            ps = ($urandom_range(0, 99) < 55);
            pp = ($urandom_range(0, 99) < 45);
            reset = ($urandom_range(0, 199) == 0);
            cyc(ps, pp, int'($urandom_range(0, 3)), DW'($urandom));
        end
        reset = 1'b0;
        cyc(0, 0, 0, 8'h00);
        cyc(0, 0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
